averaging_filter: RTL

AVERAGING_FILTER -- requirements
Module: averaging_filter

---
 rtl/avg_pkg.sv | 15 +
 rtl/sample_ring.sv | 48 ++++
 rtl/averaging_filter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/avg_pkg.sv
// Shared definitions for the moving-average filter: default widths, sample type and FSM states.
package avg_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_LOG2_N = 3;

   typedef logic signed [DEF_DATA_W-1:0] sample_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

endpackage

// File: rtl/sample_ring.sv
// Circular buffer of pre-scaled samples; the entry under the write pointer is always the oldest.
module sample_ring
   import avg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LOG2_N = DEF_LOG2_N
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en_i,
   input  logic signed [DATA_W-1:0] wr_data_i,
   output logic signed [DATA_W-1:0] oldest_o
);

   localparam int N = 1 << LOG2_N;

   logic signed [DATA_W-1:0] mem_q [N];
   logic [LOG2_N-1:0]        wptr_q;
   logic [LOG2_N-1:0]        wptr_d;

   // Next write pointer: N is a power of two, so natural overflow gives the modulo-N wrap
   always_comb begin
      wptr_d = wptr_q;
      if (wr_en_i) begin
         wptr_d = wptr_q + LOG2_N'(1);
      end else begin
         wptr_d = wptr_q;
      end
   end

   // Buffer storage and pointer; reset clears every entry so unfilled taps read as zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         if (wr_en_i) begin
            mem_q[wptr_q] <= wr_data_i;
         end
      end
   end

   assign oldest_o = mem_q[wptr_q];

endmodule

// File: rtl/averaging_filter.sv
// N-tap moving-average filter: IDLE/UPDATE/HOLD handshake FSM with a running-sum accumulator.
// Optional build macro AVG_PRIME_EN suppresses outputs until the window has been filled once.
module averaging_filter
   import avg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LOG2_N = DEF_LOG2_N
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   input  logic                     out_ready
);

   state_e                   state_q, state_d;
   logic signed [DATA_W-1:0] new_q, new_d;
   logic signed [DATA_W-1:0] sum_q, sum_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] oldest_s;
   logic                     wr_en_s;
   logic                     emit_s;

   assign wr_en_s = (state_q == ST_UPDATE);

   sample_ring #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_ring (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (wr_en_s),
      .wr_data_i (new_q),
      .oldest_o  (oldest_s)
   );

`ifdef AVG_PRIME_EN
   localparam logic [LOG2_N:0] FILL_N = (LOG2_N+1)'(1 << LOG2_N);

   logic [LOG2_N:0] fill_q, fill_d;

   // Saturating count of accepted samples; outputs open once the window is full
   always_comb begin
      fill_d = fill_q;
      if (wr_en_s && (fill_q != FILL_N)) begin
         fill_d = fill_q + (LOG2_N+1)'(1);
      end else begin
         fill_d = fill_q;
      end
      emit_s = (fill_d == FILL_N);
   end

   // Fill counter storage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end
`else
   assign emit_s = 1'b1;
`endif

   // FSM and accumulator next-state; the sample is pre-scaled so the sum never needs a divide
   always_comb begin
      state_d     = state_q;
      new_d       = new_q;
      sum_d       = sum_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               new_d   = in_data >>> LOG2_N;
               state_d = ST_UPDATE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_UPDATE: begin
            sum_d = sum_q + new_q - oldest_s;
            if (emit_s) begin
               out_valid_d = 1'b1;
               out_data_d  = sum_d;
               state_d     = ST_HOLD;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_HOLD;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State, accumulator and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         new_q       <= '0;
         sum_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         new_q       <= new_d;
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
